// File: rtl/cpu_pkg.sv
// Types and constants shared by the fetch, fetch-queue and decode stages.
package cpu_pkg;

  localparam int ADDR_W = 32;

  // Canonical no-op (addi x0, x0, 0) that decode issues for bubbles.
  localparam logic [ADDR_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] instr;
  } fetch_pkt_t;

  function automatic fetch_pkt_t make_pkt(input logic [ADDR_W-1:0] pc,
                                          input logic [ADDR_W-1:0] instr);
    fetch_pkt_t pkt;
    pkt.pc    = pc;
    pkt.instr = instr;
    return pkt;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port,
// every entry cleared while nrst is low.
module fetch_queue_mem #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] entry [DEPTH];

  // One register per entry so the asynchronous clear reaches every word.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [W-1:0] entry_reg;

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        entry_reg <= '0;
      end else if (we && (waddr == AW'(gi))) begin
        entry_reg <= wdata;
      end
    end

    assign entry[gi] = entry_reg;
  end

  assign rdata = entry[raddr];

endmodule

// File: rtl/fetch_queue.sv
// In-order {pc, instr} queue between fetch and decode with valid/ready on both
// sides, first-word fall-through output and a single-cycle flush.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_pc,
  input  logic [ADDR_W-1:0]          in_instr,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_W-1:0]          out_pc,
  output logic [ADDR_W-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg,  count_next;
  logic          push, pop;
  logic [2*ADDR_W-1:0] rdata;

  // No full-bypass: a pop in the same cycle does not open a slot for fetch.
  assign in_ready  = nrst && (count_reg != FULL);
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_next = rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Head stays stable under backpressure: wr_ptr only equals rd_ptr when full,
  // and nothing is written while full.
  fetch_queue_mem #(
    .DEPTH (DEPTH),
    .W     (2*ADDR_W),
    .AW    (PW)
  ) u_mem (
    .clk   (clk),
    .nrst  (nrst),
    .we    (push),
    .waddr (wr_ptr_reg),
    .wdata ({in_pc, in_instr}),
    .raddr (rd_ptr_reg),
    .rdata (rdata)
  );

  assign {out_pc, out_instr} = rdata;
  assign count               = count_reg;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences
// and a randomized run against a queue-based reference model.
module tb_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk;
  logic          nrst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_pc;
  logic [AW-1:0] in_instr;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [AW-1:0] out_instr;
  logic [CW-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  fetch_pkt_t mq[$];

  typedef struct {
    logic          iv;
    logic [AW-1:0] pc;
    logic [AW-1:0] ins;
    logic          ordy;
    int            e_count;
    logic          e_ov;
    logic          e_ir;
    logic          chk_head;
    logic [AW-1:0] e_pc;
    logic [AW-1:0] e_ins;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " count"}, 64'(count), 64'(mq.size()));
    chk({tag, " out_valid"}, 64'(out_valid), 64'(mq.size() != 0));
    chk({tag, " in_ready"}, 64'(in_ready), 64'(mq.size() != DEPTH));
    if (mq.size() != 0) begin
      chk({tag, " out_pc"}, 64'(out_pc), 64'(mq[0].pc));
      chk({tag, " out_instr"}, 64'(out_instr), 64'(mq[0].instr));
    end
  endtask

  // Drive one cycle of inputs, advance the reference model, check after the edge.
  task automatic cycle(input logic iv, input logic [AW-1:0] pc, input logic [AW-1:0] ins,
                       input logic fl, input logic ordy);
    int n;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = ins;
    flush     = fl;
    out_ready = ordy;
    n = mq.size();
    if (fl) begin
      mq.delete();
    end else begin
      if (ordy && n > 0) void'(mq.pop_front());
      if (iv && n < DEPTH) mq.push_back(make_pkt(pc, ins));
    end
    @(posedge clk);
    #1;
    check_model("model");
  endtask

  // Assert reset in the middle of a cycle; everything must clear without an edge.
  task automatic reset_mid(input string tag);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    chk({tag, " rst count"}, 64'(count), 64'(0));
    chk({tag, " rst out_valid"}, 64'(out_valid), 64'(0));
    chk({tag, " rst in_ready"}, 64'(in_ready), 64'(0));
    chk({tag, " rst out_pc"}, 64'(out_pc), 64'(0));
    chk({tag, " rst out_instr"}, 64'(out_instr), 64'(0));
    mq.delete();
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk({tag, " release in_ready"}, 64'(in_ready), 64'(1));
    chk({tag, " release count"}, 64'(count), 64'(0));
  endtask

  function automatic vec_t mkv(input logic iv, input logic [AW-1:0] pc, input logic [AW-1:0] ins,
                               input logic ordy, input int ec, input logic eov, input logic eir,
                               input logic ch, input logic [AW-1:0] epc, input logic [AW-1:0] eins);
    vec_t v;
    v.iv = iv; v.pc = pc; v.ins = ins; v.ordy = ordy;
    v.e_count = ec; v.e_ov = eov; v.e_ir = eir;
    v.chk_head = ch; v.e_pc = epc; v.e_ins = eins;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    in_pc = '0; in_instr = '0;

    // Fill to full, overflow attempt, drain, pop-while-empty, push-while-empty.
    vt[0]  = mkv(1, 32'h0,  32'h1234_5678, 0, 1, 1, 1, 1, 32'h0, 32'h1234_5678);
    vt[1]  = mkv(1, 32'h4,  32'hA000_0004, 0, 2, 1, 1, 1, 32'h0, 32'h1234_5678);
    vt[2]  = mkv(1, 32'h8,  32'hA000_0008, 0, 3, 1, 1, 1, 32'h0, 32'h1234_5678);
    vt[3]  = mkv(1, 32'hC,  32'hA000_000C, 0, 4, 1, 0, 1, 32'h0, 32'h1234_5678);
    vt[4]  = mkv(1, 32'h10, 32'hA000_0010, 0, 4, 1, 0, 1, 32'h0, 32'h1234_5678);
    vt[5]  = mkv(0, 32'h0,  32'h0,         1, 3, 1, 1, 1, 32'h4, 32'hA000_0004);
    vt[6]  = mkv(0, 32'h0,  32'h0,         1, 2, 1, 1, 1, 32'h8, 32'hA000_0008);
    vt[7]  = mkv(0, 32'h0,  32'h0,         1, 1, 1, 1, 1, 32'hC, 32'hA000_000C);
    vt[8]  = mkv(0, 32'h0,  32'h0,         1, 0, 0, 1, 0, 32'h0, 32'h0);
    vt[9]  = mkv(0, 32'h0,  32'h0,         1, 0, 0, 1, 0, 32'h0, 32'h0);
    vt[10] = mkv(1, 32'h20, 32'hA000_0020, 1, 1, 1, 1, 1, 32'h20, 32'hA000_0020);

    // Power-on reset
    #2 nrst = 1'b0;
    #10;
    chk("por count", 64'(count), 64'(0));
    chk("por out_valid", 64'(out_valid), 64'(0));
    chk("por in_ready", 64'(in_ready), 64'(0));
    chk("por out_pc", 64'(out_pc), 64'(0));
    @(negedge clk);
    nrst = 1'b1;
    #1;
    chk("por release in_ready", 64'(in_ready), 64'(1));

    for (int i = 0; i < 11; i++) begin
      cycle(vt[i].iv, vt[i].pc, vt[i].ins, 1'b0, vt[i].ordy);
      $display("[TB] vec %0d iv=%0b pc=%h ordy=%0b -> count=%0d out_valid=%0b in_ready=%0b out_pc=%h",
               i, vt[i].iv, vt[i].pc, vt[i].ordy, count, out_valid, in_ready, out_pc);
      chk($sformatf("vec%0d count", i), 64'(count), 64'(vt[i].e_count));
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(vt[i].e_ov));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(vt[i].e_ir));
      if (vt[i].chk_head) begin
        chk($sformatf("vec%0d out_pc", i), 64'(out_pc), 64'(vt[i].e_pc));
        chk($sformatf("vec%0d out_instr", i), 64'(out_instr), 64'(vt[i].e_ins));
      end
    end
    cycle(0, '0, '0, 0, 1);
    chk("drain count", 64'(count), 64'(0));

    // Streaming through the queue, pointers wrap more than once
    for (int i = 0; i < 10; i++) begin
      cycle(1, 32'(i*4), 32'hB000_0000 | 32'(i*4), 0, 1);
      $display("[TB] stream %0d pc=%h -> count=%0d out_pc=%h", i, 32'(i*4), count, out_pc);
      chk($sformatf("stream%0d count", i), 64'(count), 64'(1));
      chk($sformatf("stream%0d out_pc", i), 64'(out_pc), 64'(i*4));
    end
    cycle(0, '0, '0, 0, 1);
    chk("stream end count", 64'(count), 64'(0));

    // Flush with simultaneous push and pop
    for (int i = 0; i < 3; i++) cycle(1, 32'h40 + 32'(i*4), 32'hC000_0000 + 32'(i), 0, 0);
    chk("preflush count", 64'(count), 64'(3));
    cycle(1, 32'h50, 32'hDEAD_0050, 1, 1);
    $display("[TB] flush -> count=%0d out_valid=%0b", count, out_valid);
    chk("flush count", 64'(count), 64'(0));
    chk("flush out_valid", 64'(out_valid), 64'(0));
    cycle(1, 32'h100, 32'hC0DE_0100, 0, 0);
    $display("[TB] post-flush push -> count=%0d out_pc=%h", count, out_pc);
    chk("postflush out_valid", 64'(out_valid), 64'(1));
    chk("postflush out_pc", 64'(out_pc), 64'(32'h100));
    chk("postflush count", 64'(count), 64'(1));
    cycle(0, '0, '0, 0, 1);

    // Backpressure: head stays stable while fetch keeps pushing until full
    cycle(1, 32'h200, 32'hE000_0200, 0, 0);
    cycle(1, 32'h204, 32'hE000_0204, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 32'h208 + 32'(i*4), 32'hE000_0208 + 32'(i*4), 0, 0);
      $display("[TB] stall %0d -> count=%0d out_pc=%h", i, count, out_pc);
      chk($sformatf("stall%0d out_pc", i), 64'(out_pc), 64'(32'h200));
      chk($sformatf("stall%0d out_instr", i), 64'(out_instr), 64'(32'hE000_0200));
    end
    for (int i = 0; i < 4; i++) cycle(0, '0, '0, 0, 1);
    chk("stall drain count", 64'(count), 64'(0));

    // Reset in the middle of operation
    cycle(1, 32'h300, 32'hF000_0300, 0, 0);
    cycle(1, 32'h304, 32'hF000_0304, 0, 0);
    reset_mid("midop");
    $display("[TB] mid-operation reset -> count=%0d in_ready=%0b", count, in_ready);

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        reset_mid("rand");
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom, $urandom,
              $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Instruction queue between the fetch stage and the decode stage.
- Captures each {pc, instruction} pair produced by fetch and presents it to decode in order.
- Uses a valid/ready handshake on both sides.
- Decouples decode stalls from fetch and discards wrong-path instructions on a branch redirect (flush).

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
ADDR_W, 32, width of pc and instruction fields

Ports:
clk  input  1  clock; all state updates on rising edge
nrst  input  1  reset, asynchronous, active-low
in_valid  input  1  fetch presents a valid {in_pc, in_instr}
in_ready  output  1  queue can accept an entry this cycle
in_pc  input  ADDR_W  pc of fetched instruction
in_instr  input  ADDR_W  fetched instruction word
flush  input  1  synchronous discard of all entries (branch redirect)
out_valid  output  1  head entry valid for decode
out_ready  input  1  decode consumes head this cycle
out_pc  output  ADDR_W  pc of head entry
out_instr  output  ADDR_W  instruction of head entry
count  output  $clog2(DEPTH)+1  number of occupied entries

Behaviour:
- Reset (nrst low, asynchronous): rd_ptr=0, wr_ptr=0, count=0, out_valid=0, in_ready=0 while nrst low, storage cleared to 0, so out_pc=0 and out_instr=0.
- After reset release, in_ready=1 combinationally (queue empty).
- in_ready = nrst && (count != DEPTH). No push when full, even if a pop occurs the same cycle; there is no full-bypass path.
- push = in_valid && in_ready && !flush.
- pop = out_valid && out_ready && !flush.
- out_valid = (count != 0).
- out_pc and out_instr come combinationally from storage[rd_ptr] (first-word fall-through).
- Latency: an entry pushed at edge N is visible on out_* after edge N; minimum in-to-out latency is 1 cycle. There is no same-cycle bypass when empty.
- Push only: storage[wr_ptr] written, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (0 < count < DEPTH): both pointers advance, count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH naturally. count disambiguates full from empty.
- out_ready while empty: ignored, no state change, count never underflows.
- in_valid while full: ignored, data not captured. Fetch must hold its data (fetch holds pc when in_ready=0).
- flush: highest priority at the clock edge. rd_ptr=wr_ptr=0, count=0; any push or pop in that cycle is dropped. out_valid=0 from the next cycle. Storage contents are not cleared (don't care).
- flush is ignored during reset; reset always wins.
- Reset asserted mid-operation: all entries lost immediately, without waiting for a clock.
- out_* hold stable while out_valid && !out_ready (storage at rd_ptr is unchanged because wr_ptr != rd_ptr when not full, and no push occurs when full).

Decomposition:
- Shared package cpu_pkg: ADDR_W=32, NOP_INSTR constant, and a fetch-packet struct {pc, instr} used by fetch, fetch_queue and decode.
- One sub-module fetch_queue_mem: DEPTH x (2*ADDR_W) register array with one write port (we, waddr, wdata), one asynchronous read port (raddr, rdata), and asynchronous clear on nrst.
- Pointer, count and handshake logic stay in fetch_queue.

Test Plan:
- Reset check: assert nrst=0 mid-cycle → immediately count=0, out_valid=0, in_ready=0, out_pc=0. Release → in_ready=1.
- Single push: push pc=0x0, instr=0x12345678 with out_ready=0 → next cycle out_valid=1, out_pc=0x0, out_instr=0x12345678, count=1.
- Fill to full: push pcs 0x0, 0x4, 0x8, 0xC with out_ready=0 → count=4, in_ready=0. A 5th push of pc=0x10 is not captured. Then pop 4 entries → order 0x0, 0x4, 0x8, 0xC, then count=0.
- Streaming with wrap: in_valid=1 and out_ready=1 continuously for 10 pcs (0x0 to 0x24) → count stays 1 after the first push, outputs appear in order with 1-cycle lag, pointers wrap twice with no loss.
- Flush with simultaneous push/pop: count=3, assert flush with in_valid=1 and out_ready=1 → next cycle count=0, out_valid=0. A new push of pc=0x100 appears at the head the cycle after.
- Backpressure: count=2, out_ready=0 for 5 cycles → out_pc/out_instr stable across all 5 cycles.
